// File: rtl/instruction_fetch_pkg.sv
// Shared constants and FSM encoding for the PMEM -> decoder fetch path.
package instruction_fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-side bus bundle: PMEM read port, decoder instruction port and redirect input.
interface instruction_fetch_if #(
  parameter int PC_WIDTH = 32
);

  logic                pmem_req;
  logic [PC_WIDTH-1:0] pmem_addr;
  logic                pmem_ack;
  logic [31:0]         pmem_rdata;
  logic [31:0]         instr;
  logic [PC_WIDTH-1:0] instr_pc;
  logic                instr_valid;
  logic                instr_ready;
  logic                redirect;
  logic [PC_WIDTH-1:0] redirect_pc;

  modport master (
    output pmem_req, pmem_addr, instr, instr_pc, instr_valid,
    input  pmem_ack, pmem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  pmem_req, pmem_addr, instr, instr_pc, instr_valid,
    output pmem_ack, pmem_rdata, instr_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/instruction_fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries; flush empties it on the same edge.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i & (count_q != '0);
  assign do_push = push_i & ((count_q != CNT_W'(DEPTH)) | do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed through a non-zero count.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, issues single-outstanding PMEM reads and buffers words for the decoder.
//  state      | meaning
//  FETCH_IDLE | no read outstanding; issue when buffer space allows
//  FETCH_WAIT | read outstanding, returned word will be buffered
//  FETCH_DROP | read outstanding but stale after a redirect; returned word is discarded
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                  PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                  FIFO_DEPTH = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  instruction_fetch_if.master bus
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH+1);
  localparam int ENTRY_W = PC_WIDTH + 32;

  fetch_state_e        state_q;
  logic [PC_WIDTH-1:0] fetch_pc_q;
  logic [PC_WIDTH-1:0] pmem_addr_q;
  logic                pmem_req_q;

  logic                ack;
  logic                push, pop;
  logic [CNT_W-1:0]    count;
  logic [CNT_W:0]      count_next;
  logic                can_issue;
  logic                empty;
  logic [ENTRY_W-1:0]  head;
  logic [PC_WIDTH-1:0] redirect_pc_al;
  logic [PC_WIDTH-1:0] fetch_pc_inc;

  assign ack            = pmem_req_q & bus.pmem_ack;
  assign redirect_pc_al = {bus.redirect_pc[PC_WIDTH-1:2], 2'b00};
  assign fetch_pc_inc   = fetch_pc_q + PC_WIDTH'(4);
  assign push           = (state_q == FETCH_WAIT) & ack & ~bus.redirect;
  assign pop            = ~empty & bus.instr_ready & ~bus.redirect;

  // Occupancy after this edge decides whether another read may be outstanding.
  assign count_next = {1'b0, count} + {{CNT_W{1'b0}}, push} - {{CNT_W{1'b0}}, pop};
  assign can_issue  = count_next < (CNT_W+1)'(FIFO_DEPTH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FETCH_IDLE;
      fetch_pc_q  <= RESET_PC;
      pmem_req_q  <= 1'b0;
      pmem_addr_q <= RESET_PC;
    end else begin
      case (state_q)
        FETCH_IDLE: begin
          if (bus.redirect) begin
            fetch_pc_q <= redirect_pc_al;
          end else if (can_issue) begin
            state_q     <= FETCH_WAIT;
            pmem_req_q  <= 1'b1;
            pmem_addr_q <= fetch_pc_q;
          end
        end
        FETCH_WAIT: begin
          if (bus.redirect) begin
            fetch_pc_q <= redirect_pc_al;
            if (ack) begin
              state_q    <= FETCH_IDLE;
              pmem_req_q <= 1'b0;
            end else begin
              state_q <= FETCH_DROP;
            end
          end else if (ack) begin
            fetch_pc_q <= fetch_pc_inc;
            if (can_issue) begin
              pmem_addr_q <= fetch_pc_inc;
            end else begin
              state_q    <= FETCH_IDLE;
              pmem_req_q <= 1'b0;
            end
          end
        end
        FETCH_DROP: begin
          if (bus.redirect) fetch_pc_q <= redirect_pc_al;
          if (ack) begin
            state_q    <= FETCH_IDLE;
            pmem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= FETCH_IDLE;
          pmem_req_q <= 1'b0;
        end
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.redirect),
    .data_i  ({fetch_pc_q, bus.pmem_rdata}),
    .data_o  (head),
    .count_o (count),
    .empty_o (empty)
  );

  assign bus.pmem_req    = pmem_req_q;
  assign bus.pmem_addr   = pmem_addr_q;
  assign bus.instr_valid = ~empty;
  assign bus.instr       = empty ? NOP_INSTR : head[31:0];
  assign bus.instr_pc    = empty ? '0 : head[ENTRY_W-1:32];

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios then randomized traffic against a queue-based reference model.
module tb_instruction_fetch;

  localparam int          FIFO_DEPTH = 2;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instruction_fetch_if #(.PC_WIDTH(32)) bif  ();
  instruction_fetch_if #(.PC_WIDTH(32)) bif2 ();

  instruction_fetch #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif));

  instruction_fetch #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(FIFO_DEPTH)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .bus(bif2));

  // Second instance: always-ready zero-wait memory, used only for the wrap check.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
  endfunction
  assign bif2.pmem_ack    = bif2.pmem_req;
  assign bif2.pmem_rdata  = mem_word(bif2.pmem_addr);
  assign bif2.instr_ready = 1'b1;
  assign bif2.redirect    = 1'b0;
  assign bif2.redirect_pc = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  // knobs
  logic        rst_ctl, ready_k, redir_k, stray_k;
  logic [31:0] rpc_k;
  int          lat_k;

  // PMEM responder state
  logic pm_busy;
  int   pm_rem;

  // reference model
  logic [63:0] exp_q[$];
  logic [31:0] exp_addr;
  logic        in_req, stale;
  logic [31:0] held;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_addr = 32'h0;
    in_req   = 1'b0;
    stale    = 1'b0;
    held     = 32'h0;
    pm_busy  = 1'b0;
    pm_rem   = 0;
  endtask

  // One clock: drive inputs at the negedge, advance the model, then check outputs at the next negedge.
  task automatic tick();
    logic        r, a_ack;
    logic [31:0] a;
    logic [63:0] e;
    r = bif.pmem_req;
    a = bif.pmem_addr;
    a_ack = 1'b0;
    if (rst_ctl && r) begin
      if (!pm_busy) begin
        pm_busy = 1'b1;
        pm_rem  = (lat_k < 0) ? int'($urandom_range(3)) : lat_k;
      end
      if (pm_rem == 0) begin
        a_ack   = 1'b1;
        pm_busy = 1'b0;
      end else pm_rem--;
    end else if (!r) begin
      a_ack = stray_k;
    end
    rst_n           = rst_ctl;
    bif.pmem_ack    = a_ack;
    bif.pmem_rdata  = (r && a_ack) ? mem_word(a) : $urandom;
    bif.instr_ready = ready_k;
    bif.redirect    = redir_k;
    bif.redirect_pc = rpc_k;

    if (!rst_ctl) begin
      model_reset();
    end else begin
      if (in_req) chk("req_hold", {r, a}, {1'b1, held});
      else if (r) begin
        chk("req_addr", a, exp_addr);
        in_req = 1'b1;
        held   = a;
        stale  = 1'b0;
      end
      if (exp_q.size() > 0 && ready_k && !redir_k) void'(exp_q.pop_front());
      if (in_req && r && a_ack) begin
        if (!stale && !redir_k) begin
          exp_q.push_back({held, mem_word(held)});
          exp_addr = held + 32'd4;
        end
        in_req = 1'b0;
      end
      if (redir_k) begin
        exp_q.delete();
        exp_addr = rpc_k & ~32'h3;
        if (in_req) stale = 1'b1;
      end
      chk("no_overflow", exp_q.size() <= FIFO_DEPTH, 1'b1);
    end

    @(negedge clk);
    if (exp_q.size() > 0) e = exp_q[0];
    else                  e = {32'h0, NOP};
    chk("out", {bif.instr_valid, bif.instr_pc, bif.instr}, {exp_q.size() > 0, e});
  endtask

  task automatic wait_new_req(input int max, input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i <= max; i++) begin
      if (bif.pmem_req && !in_req) begin
        ok = 1'b1;
        break;
      end
      if (i < max) tick();
    end
    chk(tag, ok, 1'b1);
  endtask

  initial begin
    rst_ctl = 1'b0; ready_k = 1'b0; redir_k = 1'b0; stray_k = 1'b0;
    rpc_k = 32'h0; lat_k = 0;
    rst_n = 1'b0;
    bif.pmem_ack = 1'b0; bif.pmem_rdata = 32'h0; bif.instr_ready = 1'b0;
    bif.redirect = 1'b0; bif.redirect_pc = 32'h0;
    model_reset();
    @(negedge clk);

    // 1: zero-wait memory, decoder always ready; also the RESET_PC wrap instance
    tick(); tick();
    chk("t1_reset", {bif.pmem_req, bif.pmem_addr, bif.instr_valid}, {1'b0, 32'h0, 1'b0});
    rst_ctl = 1'b1; ready_k = 1'b1; lat_k = 0;
    tick();
    chk("t1_req0", {bif.pmem_req, bif.pmem_addr, bif.instr_valid}, {1'b1, 32'h0, 1'b0});
    chk("t5_req0", {bif2.pmem_req, bif2.pmem_addr}, {1'b1, 32'hFFFF_FFFC});
    tick();
    chk("t1_req4", {bif.pmem_req, bif.pmem_addr}, {1'b1, 32'h4});
    chk("t1_pc0", {bif.instr_valid, bif.instr_pc}, {1'b1, 32'h0});
    chk("t5_wrap", {bif2.pmem_req, bif2.pmem_addr}, {1'b1, 32'h0});
    tick();
    chk("t1_req8", {bif.pmem_req, bif.pmem_addr}, {1'b1, 32'h8});
    chk("t1_pc4", {bif.instr_valid, bif.instr_pc}, {1'b1, 32'h4});
    tick();
    chk("t1_pc8", {bif.instr_valid, bif.instr_pc}, {1'b1, 32'h8});

    // 2: slow memory with a stalled decoder fills the buffer and stops fetching
    rst_ctl = 1'b0; tick(); tick();
    rst_ctl = 1'b1; lat_k = 3; ready_k = 1'b0;
    repeat (20) tick();
    chk("t2_full", {bif.pmem_req, bif.instr_valid, bif.instr_pc}, {1'b0, 1'b1, 32'h0});
    ready_k = 1'b1;
    tick();
    chk("t2_pc4", {bif.instr_valid, bif.instr_pc}, {1'b1, 32'h4});
    wait_new_req(10, "t2_resume");
    chk("t2_addr8", bif.pmem_addr, 32'h8);

    // 3: redirect while waiting on 0x8
    lat_k = 2; redir_k = 1'b1; rpc_k = 32'h100;
    tick();
    redir_k = 1'b0;
    chk("t3_hold", {bif.pmem_req, bif.pmem_addr, bif.instr_valid}, {1'b1, 32'h8, 1'b0});
    wait_new_req(8, "t3_req");
    chk("t3_addr", bif.pmem_addr, 32'h100);
    for (int i = 0; i < 10 && !bif.instr_valid; i++) tick();
    chk("t3_first", {bif.instr_valid, bif.instr_pc}, {1'b1, 32'h100});

    // 4: redirect in the same cycle as the ack
    lat_k = 0;
    wait_new_req(8, "t4_wait");
    redir_k = 1'b1; rpc_k = 32'h203;
    tick();
    redir_k = 1'b0;
    chk("t4_flush", bif.instr_valid, 1'b0);
    wait_new_req(4, "t4_req");
    chk("t4_addr", bif.pmem_addr, 32'h200);

    // 6: reset in the middle of a read, stray ack afterwards
    lat_k = 3;
    wait_new_req(8, "t6_wait");
    tick();
    rst_ctl = 1'b0;
    tick();
    chk("t6_reset", {bif.pmem_req, bif.pmem_addr, bif.instr_valid, bif.instr}, {1'b0, 32'h0, 1'b0, NOP});
    rst_ctl = 1'b1; stray_k = 1'b1;
    tick();
    stray_k = 1'b0;
    chk("t6_restart", {bif.pmem_req, bif.pmem_addr, bif.instr_valid}, {1'b1, 32'h0, 1'b0});

    // randomized traffic
    lat_k = -1;
    for (int i = 0; i < 3000; i++) begin
      ready_k = ($urandom_range(9) < 7);
      redir_k = ($urandom_range(19) == 0);
      rpc_k   = $urandom & 32'h0000_0FFF;
      stray_k = ($urandom_range(9) == 0);
      rst_ctl = ($urandom_range(499) != 0);
      if (!rst_ctl) redir_k = 1'b0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
